// File: rtl/r5p_soc_bus_router.sv
// ----------------------------------------------------------------------------
// r5p_soc_bus_router
//
// Load/store bus router for R5P SoCs: one requester fanned out to BN slaves.
// Each slave claims the addresses that match its base (AS) on the bits set in
// its mask (AM). When several slaves match, the lowest index wins. Accesses
// that match no slave are accepted at once by an internal error slave. They
// produce a one-cycle s_err pulse in the response slot and bump a saturating
// error counter.
//
// Read data comes back RL cycles after the handshake. A small pipe of
// {valid, wen, sel, miss} records tells the response slot which slave's
// m_rdt to forward. With RL=0 the pipe is removed and the response is
// combinational.
//
// Ports
//   clk, rst                         clock, asynchronous active-low reset
//   s_vld/s_wen/s_adr/s_ben/s_wdt    requester request
//   s_rdt/s_rdy/s_err                requester read data, ready, decode error
//   m_vld[BN]                        per-slave valid (one-hot or zero)
//   m_wen/m_adr/m_ben/m_wdt          request broadcast to every slave
//   m_rdt[BN*DW], m_rdy[BN]          per-slave read data and ready
//   err_cnt, err_clr                 saturating decode-error count, clear
// ----------------------------------------------------------------------------
module r5p_soc_bus_router #(
    parameter int unsigned             BN = 3,
    parameter int unsigned             AW = 15,
    parameter int unsigned             DW = 32,
    parameter int unsigned             BW = DW/8,
    parameter int unsigned             RL = 1,
    parameter logic [BN-1:0][AW-1:0]   AS = '0,
    parameter logic [BN-1:0][AW-1:0]   AM = '0,
    parameter int unsigned             CW = 8
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            s_vld,
    input  logic            s_wen,
    input  logic [AW-1:0]   s_adr,
    input  logic [BW-1:0]   s_ben,
    input  logic [DW-1:0]   s_wdt,
    output logic [DW-1:0]   s_rdt,
    output logic            s_rdy,
    output logic            s_err,
    output logic [BN-1:0]   m_vld,
    output logic            m_wen,
    output logic [AW-1:0]   m_adr,
    output logic [BW-1:0]   m_ben,
    output logic [DW-1:0]   m_wdt,
    input  logic [BN*DW-1:0] m_rdt,
    input  logic [BN-1:0]   m_rdy,
    output logic [CW-1:0]   err_cnt,
    input  logic            err_clr
);

    localparam int unsigned SW = (BN > 1) ? $clog2(BN) : 1;

    logic [BN-1:0] hit;
    logic [SW-1:0] sel;
    logic          miss;
    logic          xfer;
    logic [DW-1:0] m_rdt_arr [BN];

    // Response slot view (either pipe output or the live decode for RL=0).
    logic          rsp_vld;
    logic          rsp_wen;
    logic          rsp_miss;
    logic [SW-1:0] rsp_sel;

    logic [CW-1:0] err_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < BN; gi++) begin : g_slave
            assign hit[gi]       = ((s_adr ^ AS[gi]) & AM[gi]) == '0;
            assign m_vld[gi]     = s_vld & ~miss & (sel == SW'(gi));
            assign m_rdt_arr[gi] = m_rdt[gi*DW +: DW];
        end
    endgenerate

    // Scan from the top down so the lowest matching index is the last write.
    always_comb begin
        sel  = '0;
        miss = 1'b1;
        for (int i = BN-1; i >= 0; i--) begin
            if (hit[i]) begin
                sel  = SW'(i);
                miss = 1'b0;
            end
        end
    end

    // The error slave is always ready, so a miss never stalls the requester.
    assign s_rdy = miss | m_rdy[sel];
    assign xfer  = s_vld & s_rdy;

    assign m_wen = s_wen;
    assign m_adr = s_adr;
    assign m_ben = s_ben;
    assign m_wdt = s_wdt;

    generate
        if (RL == 0) begin : g_bypass
            assign rsp_vld  = xfer;
            assign rsp_wen  = s_wen;
            assign rsp_miss = miss;
            assign rsp_sel  = sel;
        end else begin : g_pipe
            logic [RL-1:0]         vld_reg;
            logic [RL-1:0]         wen_reg;
            logic [RL-1:0]         miss_reg;
            logic [RL-1:0][SW-1:0] sel_reg;

            // Shift register: stage 0 takes the current handshake, stage
            // RL-1 is the response slot. It advances every cycle, so
            // back-to-back transfers never collide.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vld_reg  <= '0;
                    wen_reg  <= '0;
                    miss_reg <= '0;
                    sel_reg  <= '0;
                end else begin
                    vld_reg[0]  <= xfer;
                    wen_reg[0]  <= s_wen;
                    miss_reg[0] <= miss;
                    sel_reg[0]  <= sel;
                    for (int i = 1; i < RL; i++) begin
                        vld_reg[i]  <= vld_reg[i-1];
                        wen_reg[i]  <= wen_reg[i-1];
                        miss_reg[i] <= miss_reg[i-1];
                        sel_reg[i]  <= sel_reg[i-1];
                    end
                end
            end

            assign rsp_vld  = vld_reg[RL-1];
            assign rsp_wen  = wen_reg[RL-1];
            assign rsp_miss = miss_reg[RL-1];
            assign rsp_sel  = sel_reg[RL-1];
        end
    endgenerate

    assign s_rdt = (rsp_vld & ~rsp_wen & ~rsp_miss) ? m_rdt_arr[rsp_sel] : '0;
    assign s_err = rsp_vld & rsp_miss;

    // Clear beats increment when both happen in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_reg <= '0;
        end else if (err_clr) begin
            err_cnt_reg <= '0;
        end else if (s_err && (err_cnt_reg != '1)) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
        end
    end

    assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_r5p_soc_bus_router.sv
// ----------------------------------------------------------------------------
// tb_r5p_soc_bus_router
//
// Bench for r5p_soc_bus_router with BN=3, RL=1, CW=8. The map is:
//   slave0: addr[14:13]==2'b00, slave1: addr[14:13]==2'b10,
//   slave2: exactly 15'h2000. Everything else is unmapped.
// The reference model decodes each address by walking the slave list in
// order. It keeps expected responses in a queue tagged with the cycle they
// are due, and it counts errors as an integer clamped at 255.
// ----------------------------------------------------------------------------
module tb_r5p_soc_bus_router;

    localparam int BN = 3;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int RL = 1;
    localparam int CW = 8;

    localparam logic [AW-1:0] T_AS [BN] = '{15'h0000, 15'h4000, 15'h2000};
    localparam logic [AW-1:0] T_AM [BN] = '{15'h6000, 15'h6000, 15'h7FFF};

    logic            clk;
    logic            rst;
    logic            s_vld;
    logic            s_wen;
    logic [AW-1:0]   s_adr;
    logic [BW-1:0]   s_ben;
    logic [DW-1:0]   s_wdt;
    logic [DW-1:0]   s_rdt;
    logic            s_rdy;
    logic            s_err;
    logic [BN-1:0]   m_vld;
    logic            m_wen;
    logic [AW-1:0]   m_adr;
    logic [BW-1:0]   m_ben;
    logic [DW-1:0]   m_wdt;
    logic [BN*DW-1:0] m_rdt;
    logic [BN-1:0]   m_rdy;
    logic [CW-1:0]   err_cnt;
    logic            err_clr;

    r5p_soc_bus_router #(
        .BN (BN), .AW (AW), .DW (DW), .BW (BW), .RL (RL),
        .AS ({T_AS[2], T_AS[1], T_AS[0]}),
        .AM ({T_AM[2], T_AM[1], T_AM[0]}),
        .CW (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_vld   (s_vld),
        .s_wen   (s_wen),
        .s_adr   (s_adr),
        .s_ben   (s_ben),
        .s_wdt   (s_wdt),
        .s_rdt   (s_rdt),
        .s_rdy   (s_rdy),
        .s_err   (s_err),
        .m_vld   (m_vld),
        .m_wen   (m_wen),
        .m_adr   (m_adr),
        .m_ben   (m_ben),
        .m_wdt   (m_wdt),
        .m_rdt   (m_rdt),
        .m_rdy   (m_rdy),
        .err_cnt (err_cnt),
        .err_clr (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int due;
        bit rd;
        int sel;
        bit miss;
    } rsp_t;

    rsp_t exp_q[$];
    int   cyc       = 0;
    int   model_err = 0;

    typedef struct {
        bit            vld;
        bit            wen;
        logic [AW-1:0] adr;
        logic [BN-1:0] rdy;
        logic [BN-1:0] e_mvld;
        bit            e_rdy;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // First slave in index order whose masked base matches wins.
    function automatic void decode(input logic [AW-1:0] a, output int sel, output bit miss);
        sel  = 0;
        miss = 1'b1;
        for (int i = 0; i < BN; i++) begin
            if (((a ^ T_AS[i]) & T_AM[i]) == '0) begin
                sel  = i;
                miss = 1'b0;
                break;
            end
        end
    endfunction

    // Drive one cycle of inputs and check every output against the model.
    // Entered and left at posedge+1.
    task automatic do_cycle(input bit rst_i, input bit vld_i, input bit wen_i,
                            input logic [AW-1:0] adr_i, input logic [BN-1:0] rdy_i,
                            input bit clr_i);
        int            sel;
        bit            miss;
        bit            xfer;
        logic [DW-1:0] e_rdt;
        bit            e_err;
        logic [BN-1:0] e_mvld;
        logic [BW-1:0] ben;
        rsp_t          r;
        ben     = BW'($urandom);
        rst     = rst_i;
        s_vld   = vld_i;
        s_wen   = wen_i;
        s_adr   = adr_i;
        s_ben   = ben;
        s_wdt   = $urandom;
        m_rdy   = rdy_i;
        err_clr = clr_i;
        if (!rst_i) begin
            exp_q.delete();
            model_err = 0;
        end
        #2;
        decode(adr_i, sel, miss);
        e_mvld = (vld_i && !miss) ? BN'(1 << sel) : '0;
        chk("m_vld", 64'(m_vld), 64'(e_mvld));
        chk("s_rdy", 64'(s_rdy), miss ? 64'd1 : 64'(rdy_i[sel]));
        chk("m_adr", 64'(m_adr), 64'(adr_i));
        chk("m_ben", 64'(m_ben), 64'(ben));
        e_rdt = '0;
        e_err = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            r = exp_q.pop_front();
            if (r.miss) e_err = 1'b1;
            else if (r.rd) e_rdt = m_rdt[r.sel*DW +: DW];
        end
        chk("s_rdt", 64'(s_rdt), 64'(e_rdt));
        chk("s_err", 64'(s_err), 64'(e_err));
        chk("err_cnt", 64'(err_cnt), 64'(model_err));
        $display("[TB] cyc %0d rst=%0b vld=%0b wen=%0b adr=%h rdy=%b clr=%0b -> mvld=%b srdy=%0b rdt=%h err=%0b cnt=%0d",
                 cyc, rst_i, vld_i, wen_i, adr_i, rdy_i, clr_i, m_vld, s_rdy, s_rdt, s_err, err_cnt);
        xfer = rst_i && vld_i && (miss || rdy_i[sel]);
        if (xfer) exp_q.push_back('{due: cyc + RL, rd: !wen_i, sel: sel, miss: miss});
        if (!rst_i || clr_i) model_err = 0;
        else if (e_err && model_err < 255) model_err++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        bit            stalled;
        bit            vld_r;
        bit            wen_r;
        logic [AW-1:0] adr_r;
        logic [BN-1:0] rdy_r;
        int            sel_r;
        bit            miss_r;
        logic [AW-1:0] adr_pool [6];

        rst = 1'b0; s_vld = 0; s_wen = 0; s_adr = '0; s_ben = '0; s_wdt = '0;
        m_rdt = '0; m_rdy = '0; err_clr = 0;

        // Reset state
        #1;
        do_cycle(0, 0, 0, 15'h0000, 3'b111, 0);
        do_cycle(0, 0, 0, 15'h0000, 3'b111, 0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_s_err", 64'(s_err), 64'd0);
        do_cycle(1, 0, 0, 15'h0000, 3'b111, 0);

        // Decode table
        vt[0] = '{1, 1, 15'h4000, 3'b111, 3'b010, 1};
        vt[1] = '{1, 1, 15'h4000, 3'b101, 3'b010, 0};
        vt[2] = '{1, 0, 15'h0010, 3'b111, 3'b001, 1};
        vt[3] = '{1, 0, 15'h1FFF, 3'b110, 3'b001, 0};
        vt[4] = '{1, 0, 15'h2000, 3'b011, 3'b100, 0};
        vt[5] = '{1, 0, 15'h2001, 3'b000, 3'b000, 1};
        vt[6] = '{1, 0, 15'h6000, 3'b000, 3'b000, 1};
        vt[7] = '{0, 0, 15'h4004, 3'b000, 3'b000, 0};
        vt[8] = '{1, 1, 15'h5FFF, 3'b010, 3'b010, 1};
        for (int i = 0; i < 9; i++) begin
            s_vld = vt[i].vld; s_wen = vt[i].wen; s_adr = vt[i].adr; m_rdy = vt[i].rdy;
            #1;
            chk($sformatf("vec%0d_m_vld", i), 64'(m_vld), 64'(vt[i].e_mvld));
            chk($sformatf("vec%0d_s_rdy", i), 64'(s_rdy), 64'(vt[i].e_rdy));
            do_cycle(1, vt[i].vld, vt[i].wen, vt[i].adr, vt[i].rdy, 0);
        end
        do_cycle(1, 0, 0, 15'h0000, 3'b111, 1);

        // Write to slave1: no error in the response slot
        do_cycle(1, 1, 1, 15'h4000, 3'b111, 0);
        chk("t1_s_err", 64'(s_err), 64'd0);

        // Single read, one cycle latency
        m_rdt = {32'h0, 32'h0, 32'hDEADBEEF};
        do_cycle(1, 1, 0, 15'h0010, 3'b111, 0);
        chk("t2_rdt_slot", 64'(s_rdt), 64'hDEADBEEF);
        do_cycle(1, 0, 0, 15'h0010, 3'b111, 0);
        chk("t2_rdt_after", 64'(s_rdt), 64'd0);

        // Back-to-back reads to two slaves
        m_rdt = {32'h33333333, 32'h22222222, 32'h11111111};
        do_cycle(1, 1, 0, 15'h0010, 3'b111, 0);
        chk("t3_rdt0", 64'(s_rdt), 64'h11111111);
        do_cycle(1, 1, 0, 15'h4004, 3'b111, 0);
        chk("t3_rdt1", 64'(s_rdt), 64'h22222222);
        do_cycle(1, 0, 0, 15'h0000, 3'b111, 0);

        // Unmapped read, then counter saturation and clear priority
        do_cycle(1, 0, 0, 15'h0000, 3'b111, 1);
        do_cycle(1, 1, 0, 15'h6000, 3'b000, 0);
        chk("t4_err_pulse", 64'(s_err), 64'd1);
        chk("t4_rdt_zero", 64'(s_rdt), 64'd0);
        do_cycle(1, 0, 0, 15'h0000, 3'b000, 0);
        chk("t4_cnt_one", 64'(err_cnt), 64'd1);
        for (int i = 0; i < 300; i++) do_cycle(1, 1, i[0], 15'h6000, 3'b000, 0);
        do_cycle(1, 0, 0, 15'h0000, 3'b000, 0);
        chk("t4_cnt_sat", 64'(err_cnt), 64'd255);
        do_cycle(1, 1, 0, 15'h6000, 3'b000, 0);
        do_cycle(1, 1, 0, 15'h6000, 3'b000, 1);
        chk("t4_cnt_clr", 64'(err_cnt), 64'd0);
        do_cycle(1, 0, 0, 15'h0000, 3'b111, 0);

        // Stall on slave0 for three cycles
        m_rdt = {32'h0, 32'h0, 32'hCAFEF00D};
        for (int i = 0; i < 3; i++) begin
            do_cycle(1, 1, 0, 15'h0010, 3'b110, 0);
            chk("t5_stall_rdt", 64'(s_rdt), 64'd0);
            chk("t5_stall_err", 64'(s_err), 64'd0);
        end
        do_cycle(1, 1, 0, 15'h0010, 3'b111, 0);
        chk("t5_rdt", 64'(s_rdt), 64'hCAFEF00D);
        do_cycle(1, 0, 0, 15'h0000, 3'b111, 0);

        // Reset with a read in flight
        m_rdt = {32'h0, 32'h0, 32'h12345678};
        do_cycle(1, 1, 0, 15'h6000, 3'b111, 0);
        do_cycle(1, 1, 0, 15'h0010, 3'b111, 0);
        do_cycle(0, 0, 0, 15'h0000, 3'b111, 0);
        chk("t6_rdt", 64'(s_rdt), 64'd0);
        chk("t6_err", 64'(s_err), 64'd0);
        chk("t6_cnt", 64'(err_cnt), 64'd0);
        do_cycle(1, 0, 0, 15'h0000, 3'b111, 0);
        do_cycle(1, 1, 0, 15'h0010, 3'b111, 0);
        chk("t6_rdt_new", 64'(s_rdt), 64'h12345678);
        do_cycle(1, 0, 0, 15'h0000, 3'b111, 0);

        // Random traffic; a stalled request is held until it is accepted
        adr_pool = '{15'h0010, 15'h4004, 15'h2000, 15'h6000, 15'h1FFC, 15'h2004};
        stalled = 0;
        vld_r = 0; wen_r = 0; adr_r = '0; rdy_r = '0;
        for (int i = 0; i < 500; i++) begin
            m_rdt = {$urandom, $urandom, $urandom};
            if (!stalled) begin
                vld_r = ($urandom_range(0, 3) != 0);
                wen_r = $urandom_range(0, 1) == 1;
                adr_r = ($urandom_range(0, 3) == 0) ? AW'($urandom) : adr_pool[$urandom_range(0, 5)];
            end
            rdy_r = BN'($urandom) | BN'($urandom);
            decode(adr_r, sel_r, miss_r);
            stalled = vld_r && !miss_r && !rdy_r[sel_r];
            do_cycle(1, vld_r, wen_r, adr_r, rdy_r, $urandom_range(0, 15) == 0);
        end
        do_cycle(1, 0, 0, 15'h0000, 3'b111, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
